// File: rtl/cdr_loop_filter.sv
// CDR loop filter and phase accumulator.
// Majority-votes bang-bang PD samples over a fixed window, then applies a
// proportional + integral update to a wrapping phase code that drives the
// phase interpolator ([9:8] quadrant, [7:0] interpolation weight).
`timescale 1ns/1ps
module cdr_loop_filter #(
  parameter int VOTE_LEN   = 8,
  parameter int KP         = 4,
  parameter int KI_SHIFT   = 4,
  parameter int INT_WIDTH  = 12,
  parameter int CODE_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  Rst_n,
  input  logic                  En,
  input  logic                  Up,
  input  logic                  Dn,
  input  logic                  Freeze,
  input  logic                  Load,
  input  logic [CODE_WIDTH-1:0] Load_Code,
  output logic [CODE_WIDTH-1:0] Code,
  output logic                  Code_Valid,
  output logic                  Int_Sat
);

  localparam int NET_W = $clog2(VOTE_LEN) + 2;
  localparam int CNT_W = $clog2(VOTE_LEN + 1);

  // Integral limits are symmetric: +/-(2^(INT_WIDTH-1)-1).
  localparam logic signed [INT_WIDTH-1:0] INT_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic signed [INT_WIDTH-1:0] INT_MIN = {1'b1, {(INT_WIDTH-2){1'b0}}, 1'b1};
  localparam logic signed [INT_WIDTH:0]   SUM_MAX = {2'b00, {(INT_WIDTH-1){1'b1}}};
  localparam logic signed [INT_WIDTH:0]   SUM_MIN = {2'b11, {(INT_WIDTH-2){1'b0}}, 1'b1};

  typedef enum logic {ACC, UPD} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [NET_W-1:0] net_q, net_d;
  logic signed [INT_WIDTH-1:0] integ_q, integ_d;
  logic [CODE_WIDTH-1:0]   code_q, code_d;
  logic                    cv_q, cv_d;
  logic                    sat_q, sat_d;

  logic signed [NET_W-1:0]     vote;
  logic signed [1:0]           dec;
  logic signed [INT_WIDTH:0]   integ_sum;
  logic signed [INT_WIDTH-1:0] integ_new;
  logic signed [INT_WIDTH-1:0] integ_shr;
  logic signed [31:0]          p_term;
  logic signed [31:0]          i_term;

  // Per-sample vote and the decision datapath evaluated on the window result.
  always_comb begin
    vote = '0;
    if (Up && !Dn)      vote = {{(NET_W-1){1'b0}}, 1'b1};
    else if (Dn && !Up) vote = '1;

    dec = '0;
    if (net_q[NET_W-1]) dec = 2'sb11;
    else if (|net_q)    dec = 2'sb01;

    integ_sum = {integ_q[INT_WIDTH-1], integ_q} + {{(INT_WIDTH-1){dec[1]}}, dec};
    if (integ_sum > SUM_MAX)      integ_new = INT_MAX;
    else if (integ_sum < SUM_MIN) integ_new = INT_MIN;
    else                          integ_new = integ_sum[INT_WIDTH-1:0];

    integ_shr = integ_new >>> KI_SHIFT;
    i_term    = {{(32-INT_WIDTH){integ_shr[INT_WIDTH-1]}}, integ_shr};

    p_term = '0;
    if (dec == 2'sb01)      p_term = KP;
    else if (dec == 2'sb11) p_term = -KP;
  end

  // Next-state logic: Load over Freeze over the ACC/UPD window sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    net_d   = net_q;
    integ_d = integ_q;
    code_d  = code_q;
    cv_d    = 1'b0;
    sat_d   = sat_q;

    if (Load) begin
      code_d  = Load_Code;
      integ_d = '0;
      cnt_d   = '0;
      net_d   = '0;
      state_d = ACC;
      cv_d    = 1'b1;
      sat_d   = 1'b0;
    end else if (Freeze) begin
      cnt_d   = '0;
      net_d   = '0;
      state_d = ACC;
    end else begin
      unique case (state_q)
        ACC: begin
          if (En) begin
            net_d = net_q + vote;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(VOTE_LEN - 1)) state_d = UPD;
          end
        end
        UPD: begin
          integ_d = integ_new;
          // Step is summed wide, then truncated so the code wraps modulo 2^CODE_WIDTH.
          code_d  = code_q + CODE_WIDTH'(p_term + i_term);
          cv_d    = 1'b1;
          sat_d   = (integ_new == INT_MAX) || (integ_new == INT_MIN);
          cnt_d   = '0;
          net_d   = '0;
          state_d = ACC;
        end
        default: state_d = ACC;
      endcase
    end
  end

  // State, accumulators and registered outputs.
  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ACC;
      cnt_q   <= '0;
      net_q   <= '0;
      integ_q <= '0;
      code_q  <= '0;
      cv_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      net_q   <= net_d;
      integ_q <= integ_d;
      code_q  <= code_d;
      cv_q    <= cv_d;
      sat_q   <= sat_d;
    end
  end

  assign Code       = code_q;
  assign Code_Valid = cv_q;
  assign Int_Sat    = sat_q;

endmodule

// File: tb/tb_cdr_loop_filter.sv
// Self-checking bench for cdr_loop_filter: a behavioural model pushes the
// expected code / saturation flag per decision, and a monitor pops and
// compares whenever Code_Valid is seen.
`timescale 1ns/1ps
module tb_cdr_loop_filter;

  localparam int VOTE_LEN   = 8;
  localparam int KP         = 4;
  localparam int KI_SHIFT   = 4;
  localparam int INT_WIDTH  = 12;
  localparam int CODE_WIDTH = 10;
  localparam int INT_LIM    = (1 << (INT_WIDTH - 1)) - 1;
  localparam int CODE_MASK  = (1 << CODE_WIDTH) - 1;

  logic                  CLK = 1'b0;
  logic                  Rst_n, En, Up, Dn, Freeze, Load;
  logic [CODE_WIDTH-1:0] Load_Code;
  logic [CODE_WIDTH-1:0] Code;
  logic                  Code_Valid;
  logic                  Int_Sat;

  cdr_loop_filter #(
    .VOTE_LEN  (VOTE_LEN),
    .KP        (KP),
    .KI_SHIFT  (KI_SHIFT),
    .INT_WIDTH (INT_WIDTH),
    .CODE_WIDTH(CODE_WIDTH)
  ) dut (
    .CLK       (CLK),
    .Rst_n     (Rst_n),
    .En        (En),
    .Up        (Up),
    .Dn        (Dn),
    .Freeze    (Freeze),
    .Load      (Load),
    .Load_Code (Load_Code),
    .Code      (Code),
    .Code_Valid(Code_Valid),
    .Int_Sat   (Int_Sat)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int code;
    int sat;
  } exp_t;

  exp_t sb[$];
  int   cv_times[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;
  int   m_code   = 0;
  int   m_integ  = 0;

  task automatic check_eq(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  always @(posedge CLK) cycle++;

  // Scoreboard consumer: every Code_Valid pulse must match the next expectation.
  always @(negedge CLK) begin
    if (Rst_n === 1'b1 && Code_Valid === 1'b1) begin
      cv_times.push_back(cycle);
      if (sb.size() == 0) begin
        check_eq("unexpected_valid", 1, 0);
      end else begin
        e_mon = sb.pop_front();
        check_eq("sb_code", int'(Code), e_mon.code);
        check_eq("sb_int_sat", int'(Int_Sat), e_mon.sat);
      end
    end
  end

  function automatic int floor_shift(input int a);
    int d;
    d = 1 << KI_SHIFT;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  // Model of one decision; pushes the expected outputs.
  task automatic push_window(input int net);
    int dec;
    int step;
    exp_t e;
    dec = (net > 0) ? 1 : ((net < 0) ? -1 : 0);
    m_integ = m_integ + dec;
    if (m_integ > INT_LIM)  m_integ = INT_LIM;
    if (m_integ < -INT_LIM) m_integ = -INT_LIM;
    step   = dec * KP + floor_shift(m_integ);
    m_code = (m_code + step) & CODE_MASK;
    e.code = m_code;
    e.sat  = (m_integ == INT_LIM || m_integ == -INT_LIM) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic drive(input bit en, input bit up, input bit dn);
    En = en;
    Up = up;
    Dn = dn;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  // One full window; the UPD cycle either idles or keeps En high with Up=1.
  task automatic run_window(input logic [7:0] ups, input logic [7:0] dns, input bit keep_en);
    int net;
    net = 0;
    for (int i = 0; i < VOTE_LEN; i++) begin
      drive(1'b1, ups[i], dns[i]);
      if (ups[i] && !dns[i]) net++;
      if (dns[i] && !ups[i]) net--;
    end
    push_window(net);
    if (keep_en) drive(1'b1, 1'b1, 1'b0);
    else         drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0; En = 1'b0; Up = 1'b1; Dn = 1'b0;
    Freeze = 1'b0; Load = 1'b0; Load_Code = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_code", int'(Code), 0);
    check_eq("rst_cv", int'(Code_Valid), 0);
    check_eq("rst_int_sat", int'(Int_Sat), 0);
    Rst_n = 1'b1;
    Up = 1'b0;
    sb.delete();
    m_code  = 0;
    m_integ = 0;
  endtask

  task automatic do_load(input int v, input bit frz);
    exp_t e;
    Load = 1'b1;
    Load_Code = CODE_WIDTH'(v);
    Freeze = frz;
    m_code  = v;
    m_integ = 0;
    e.code = v;
    e.sat  = 0;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    Load = 1'b0;
    Freeze = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int q;
    Rst_n = 1'b0; En = 1'b0; Up = 1'b0; Dn = 1'b0;
    Freeze = 1'b0; Load = 1'b0; Load_Code = '0;

    // Reset with clock running and Up high, then idle with En low.
    do_reset();
    idle(5);
    check_eq("t1_idle_code", int'(Code), 0);
    check_eq("t1_idle_cv", int'(Code_Valid), 0);

    // First window: Code_Valid in cycle 10, once.
    do_reset();
    run_window(8'hFF, 8'h00, 1'b0);
    check_eq("t2_cv_cycle10", int'(Code_Valid), 1);
    check_eq("t2_code", int'(Code), 4);
    idle(1);
    check_eq("t2_cv_once", int'(Code_Valid), 0);

    // 16 back-to-back Up windows, En held high throughout.
    do_reset();
    idle(1);
    cv_times.delete();
    for (int w = 0; w < 16; w++) run_window(8'hFF, 8'h00, 1'b1);
    idle(2);
    check_eq("t3_code65", int'(Code), 65);
    check_eq("t3_cv_count", cv_times.size(), 16);
    for (int i = 1; i < cv_times.size(); i++)
      check_eq("t3_cv_spacing", cv_times[i] - cv_times[i-1], VOTE_LEN + 1);

    // Load then wrap across the top of the code range; Load beats Freeze.
    do_reset();
    do_load(1022, 1'b0);
    idle(1);
    run_window(8'hFF, 8'h00, 1'b0);
    idle(1);
    check_eq("t4_wrap_code", int'(Code), 2);
    check_eq("t4_quadrant", int'(Code[9:8]), 0);
    do_load(5, 1'b1);
    check_eq("t4_load_frz_cv", int'(Code_Valid), 1);
    check_eq("t4_load_frz_code", int'(Code), 5);
    idle(1);

    // Single Dn window from reset: negative integral rounds toward -inf.
    do_reset();
    run_window(8'h00, 8'hFF, 1'b0);
    idle(1);
    check_eq("t5_code", int'(Code), 1019);
    check_eq("t5_quadrant", int'(Code[9:8]), 3);

    // Mixed votes, a tied window, and Freeze aborting a partial window.
    do_reset();
    run_window(8'b1000_1111, 8'b1111_0000, 1'b0);
    check_eq("t6_mixed_code", int'(Code), 4);
    run_window(8'h0F, 8'hF0, 1'b0);
    check_eq("t6_tie_cv", int'(Code_Valid), 1);
    check_eq("t6_tie_code", int'(Code), 4);
    do_reset();
    do_load(500, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
    Freeze = 1'b1;
    idle(1);
    Freeze = 1'b0;
    run_window(8'h00, 8'hFF, 1'b0);
    check_eq("t6_freeze_code", int'(Code), 495);

    // Freeze during the UPD cycle discards the update.
    for (int i = 0; i < VOTE_LEN; i++) drive(1'b1, 1'b1, 1'b0);
    Freeze = 1'b1;
    idle(1);
    Freeze = 1'b0;
    idle(2);
    check_eq("t6_upd_frz_code", int'(Code), 495);
    run_window(8'hFF, 8'h00, 1'b0);
    idle(1);

    // Asynchronous reset mid-window leaves no partial state behind.
    do_load(300, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0);
    Rst_n = 1'b0;
    #1;
    check_eq("t7_async_code", int'(Code), 0);
    check_eq("t7_async_cv", int'(Code_Valid), 0);
    @(posedge CLK);
    #1;
    Rst_n = 1'b1;
    sb.delete();
    m_code  = 0;
    m_integ = 0;
    run_window(8'hFF, 8'h00, 1'b0);
    check_eq("t7_full_window_cv", int'(Code_Valid), 1);
    check_eq("t7_code", int'(Code), 4);

    // Drive the integral into positive saturation and back out.
    do_reset();
    for (int w = 0; w < INT_LIM + 3; w++) run_window(8'hFF, 8'h00, 1'b1);
    idle(2);
    check_eq("t8_int_sat", int'(Int_Sat), 1);
    run_window(8'h00, 8'hFF, 1'b0);
    idle(1);
    check_eq("t8_int_unsat", int'(Int_Sat), 0);
    run_window(8'hFF, 8'h00, 1'b0);
    idle(1);
    check_eq("t8_int_resat", int'(Int_Sat), 1);
    do_load(0, 1'b0);
    check_eq("t8_load_clr_sat", int'(Int_Sat), 0);

    idle(3);
    q = sb.size();
    check_eq("sb_drain", q, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
